gate_sweep_ctrl: RTL and testbench
==================================

// Module: gate_sweep_ctrl
// PURPOSE
//   Sequencing controller for a combinational gate under test (GUT).
//   - On start, drives every input vector 0 .. 2**N_IN-1 onto the GUT in ascending order.
//   - Waits a fixed settle time per vector, samples the GUT output and builds the captured truth table.
//   - Compares the captured table with the expected table and reports pass/fail per vector.
//   - Sits between a test/config host and any basic gate (and, or, xor, ...).
// PARAMETERS
//   N_IN           2   GUT input count; legal range 1..4; vector count V = 2**N_IN
//   SETTLE_CYCLES  2   cycles gate_in is held before sampling; legal range 1..15
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      reset, asynchronous, active-low
//   start      in   1      begin a sweep; honoured only in IDLE
//   abort      in   1      synchronous abort of a running sweep
//   exp_tt     in   V      expected truth table, bit i = expected Y for vector i
//   gate_y     in   1      GUT output Y
//   gate_in    out  N_IN   vector driven to the GUT inputs (bit 0 = first input)
//   busy       out  1      sweep in progress
//   done       out  1      one-cycle pulse, sweep complete
//   pass       out  1      captured_tt == expected; valid from done until next start
//   captured   out  V      sampled truth table, bit i = Y for vector i
//   fail_mask  out  V      captured ^ expected; valid from done until next start
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE; all outputs 0, including gate_in, busy, done, pass, captured and fail_mask.
//   All outputs are registered.
//   FSM states: IDLE, SETTLE, SAMPLE.
//   IDLE:
//     - start=1 at an edge: latch exp_tt internally; idx=0; gate_in<=0; cnt<=SETTLE_CYCLES.
//     - Same edge: busy<=1; pass, captured and fail_mask <=0; go to SETTLE.
//   SETTLE:
//     - cnt decrements each edge; gate_in is held.
//     - When cnt reaches 1, go to SAMPLE on that edge.
//     - Result: exactly SETTLE_CYCLES cycles are spent in SETTLE per vector.
//   SAMPLE (one cycle per vector):
//     - captured[idx]<=gate_y.
//     - If idx<V-1: idx<=idx+1; gate_in<=idx+1; cnt<=SETTLE_CYCLES; go to SETTLE.
//     - If idx==V-1: busy<=0; done<=1 for the next cycle only; go to IDLE.
//     - Same final edge: fail_mask<={gate_y,captured[V-2:0]}^exp_latched; pass<=(that value==0).
//   Latency: done rises V*(SETTLE_CYCLES+1) edges after the start edge (N_IN=2, S=2: 12 edges).
//   start:
//     - Ignored while busy=1.
//     - start=1 in the done-high cycle is accepted (state is already IDLE).
//     - The new sweep clears pass, captured and fail_mask.
//   abort:
//     - Checked in SETTLE/SAMPLE and has priority over sampling.
//     - Next edge: IDLE, busy=0, gate_in=0, no done pulse.
//     - captured holds its partial value; pass stays 0.
//     - abort in IDLE has no effect; abort and start together in IDLE: start wins.
//   Async reset mid-sweep: immediate return to reset values; a sweep never resumes.
//   exp_tt changes during a sweep have no effect (the latched copy is used).
//   idx and gate_in never exceed V-1; there is no wrap-around within a sweep.
// TESTING
//   1 GUT = and; start with exp_tt=4'b1000 -> gate_in steps 0,1,2,3 every 3 cycles;
//     done at edge 12; pass=1; captured=4'b1000; fail_mask=0.
//   2 GUT = and; exp_tt=4'b1110 (or table) -> done at edge 12; pass=0; captured=4'b1000; fail_mask=4'b0110.
//   3 start re-pulsed at edges 3 and 7 of a sweep -> ignored; done still at edge 12 only, single pulse.
//   4 rst_n low at edge 5 -> outputs zero immediately, without waiting for a clock edge;
//     after release, no activity until start.
//   5 abort at edge 7 -> next edge busy=0, gate_in=0; no done; captured=4'b0000 for and.
//   6 start held high through the done cycle -> second sweep begins;
//     pass/captured cleared and done again 12 edges later; SETTLE_CYCLES=1 variant: done at edge 8.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gate_sweep_ctrl
// Brief   : Drives every input vector onto a combinational gate under test,
//           captures its truth table and compares it against an expected one.
// Rev     : 1.0  initial release
// ============================================================================
module gate_sweep_ctrl #(
   parameter int N_IN          = 2,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic [(1<<N_IN)-1:0]  exp_tt,
   input  logic                  gate_y,
   output logic [N_IN-1:0]       gate_in,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [(1<<N_IN)-1:0]  captured,
   output logic [(1<<N_IN)-1:0]  fail_mask
);

   localparam int V = 1 << N_IN;

   localparam logic [1:0]      c_IDLE        = 2'd0;
   localparam logic [1:0]      c_SETTLE      = 2'd1;
   localparam logic [1:0]      c_SAMPLE      = 2'd2;
   localparam logic [3:0]      c_SETTLE_LOAD = 4'(SETTLE_CYCLES);
   localparam logic [N_IN-1:0] c_IDX_LAST    = '1;

   logic [1:0]      r_state;
   logic [1:0]      w_state;
   logic [V-1:0]    r_exp,  w_exp;
   logic [3:0]      r_cnt,  w_cnt;
   logic [N_IN-1:0] r_gate_in, w_gate_in;
   logic            r_busy, w_busy;
   logic            r_done, w_done;
   logic            r_pass, w_pass;
   logic [V-1:0]    r_cap,  w_cap;
   logic [V-1:0]    r_fail, w_fail;
   logic [V-1:0]    w_cap_smp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state;
      end
   end

   always_comb begin
      w_state = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_state = c_SETTLE;
            end
         end
         c_SETTLE: begin
            if (abort) begin
               w_state = c_IDLE;
            end else if (r_cnt == 4'd1) begin
               w_state = c_SAMPLE;
            end
         end
         c_SAMPLE: begin
            if (abort || (r_gate_in == c_IDX_LAST)) begin
               w_state = c_IDLE;
            end else begin
               w_state = c_SETTLE;
            end
         end
         default: w_state = c_IDLE;
      endcase
   end

   // The driven vector doubles as the sweep index: they are equal throughout a sweep.
   always_comb begin
      w_exp     = r_exp;
      w_cnt     = r_cnt;
      w_gate_in = r_gate_in;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_pass    = r_pass;
      w_cap     = r_cap;
      w_fail    = r_fail;
      w_cap_smp = r_cap;
      w_cap_smp[r_gate_in] = gate_y;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               w_exp     = exp_tt;
               w_cnt     = c_SETTLE_LOAD;
               w_gate_in = '0;
               w_busy    = 1'b1;
               w_pass    = 1'b0;
               w_cap     = '0;
               w_fail    = '0;
            end
         end
         c_SETTLE: begin
            if (abort) begin
               w_busy    = 1'b0;
               w_gate_in = '0;
            end else begin
               w_cnt = r_cnt - 4'd1;
            end
         end
         c_SAMPLE: begin
            if (abort) begin
               w_busy    = 1'b0;
               w_gate_in = '0;
            end else begin
               w_cap = w_cap_smp;
               if (r_gate_in == c_IDX_LAST) begin
                  w_busy = 1'b0;
                  w_done = 1'b1;
                  w_fail = w_cap_smp ^ r_exp;
                  w_pass = ~|(w_cap_smp ^ r_exp);
               end else begin
                  w_gate_in = r_gate_in + N_IN'(1);
                  w_cnt     = c_SETTLE_LOAD;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_exp     <= '0;
         r_cnt     <= '0;
         r_gate_in <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_cap     <= '0;
         r_fail    <= '0;
      end else begin
         r_exp     <= w_exp;
         r_cnt     <= w_cnt;
         r_gate_in <= w_gate_in;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_pass    <= w_pass;
         r_cap     <= w_cap;
         r_fail    <= w_fail;
      end
   end

   assign gate_in   = r_gate_in;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign captured  = r_cap;
   assign fail_mask = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gate_sweep_ctrl
// Brief   : Self-checking bench for gate_sweep_ctrl (SETTLE 2 and SETTLE 1 copies).
// Rev     : 1.0  initial release
// ============================================================================
module tb_gate_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] exp_tt = 4'd0;
   logic [3:0] gut = 4'd0;
   logic       chk_en = 1'b0;

   logic       gy0, gy1, busy0, busy1, done0, done1, pass0, pass1;
   logic [1:0] gin0, gin1;
   logic [3:0] cap0, cap1, fm0, fm1;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign gy0 = gut[gin0];
   assign gy1 = gut[gin1];

   gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
      .gate_y(gy0), .gate_in(gin0), .busy(busy0), .done(done0), .pass(pass0),
      .captured(cap0), .fail_mask(fm0));

   gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_tt(exp_tt),
      .gate_y(gy1), .gate_in(gin1), .busy(busy1), .done(done1), .pass(pass1),
      .captured(cap1), .fail_mask(fm1));

   // Sweep-level reference: position within a sweep is just the edge count since start.
   typedef struct packed {
      logic       active;
      logic [7:0] t;
      logic [3:0] exp;
      logic [3:0] cap;
      logic [3:0] fail;
      logic       pass;
      logic       done;
      logic       busy;
      logic [1:0] gin;
   } mdl_t;

   function automatic mdl_t step(mdl_t m, int s, logic st, logic ab, logic [3:0] e, logic [3:0] g);
      mdl_t n;
      int   j;
      n = m;
      n.done = 1'b0;
      if (!m.active) begin
         if (st) begin
            n.active = 1'b1; n.t = 8'd0; n.exp = e; n.cap = 4'd0;
            n.fail = 4'd0; n.pass = 1'b0; n.busy = 1'b1; n.gin = 2'd0;
         end
      end else if (ab) begin
         n.active = 1'b0; n.busy = 1'b0; n.gin = 2'd0;
      end else begin
         n.t = m.t + 8'd1;
         if ((int'(n.t) % (s + 1)) == 0) begin
            j = int'(n.t) / (s + 1) - 1;
            n.cap[j] = g[j];
            if (j == 3) begin
               n.active = 1'b0; n.busy = 1'b0; n.done = 1'b1;
               n.fail = n.cap ^ m.exp;
               n.pass = (n.fail == 4'd0);
            end else begin
               n.gin = 2'(j + 1);
            end
         end
      end
      return n;
   endfunction

   function automatic logic [12:0] mobs(mdl_t m);
      return {m.busy, m.done, m.pass, m.gin, m.cap, m.fail};
   endfunction

   mdl_t m0, m1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m0 <= '0;
         m1 <= '0;
      end else begin
         m0 <= step(m0, 2, start, abort, exp_tt, gut);
         m1 <= step(m1, 1, start, abort, exp_tt, gut);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("cyc0", 32'({busy0, done0, pass0, gin0, cap0, fm0}), 32'(mobs(m0)));
            chk("cyc1", 32'({busy1, done1, pass1, gin1, cap1, fm1}), 32'(mobs(m1)));
         end
      end
   end

   typedef struct {
      string      name;
      logic [3:0] gut;
      logic [3:0] exp;
      int         abort_at;
      int         rs_a;
      int         rs_b;
      logic [3:0] cap0;
      logic [3:0] fail0;
      logic       pass0;
      int         done0;
      logic [3:0] cap1;
      logic [3:0] fail1;
      logic       pass1;
      int         done1;
   } vec_t;

   vec_t tbl[8];

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v);
      int d0, d1, c0, c1;
      do_reset();
      gut = v.gut; exp_tt = v.exp; start = 1'b1; abort = 1'b0;
      d0 = -1; d1 = -1; c0 = 0; c1 = 0;
      for (int e = 0; e < 16; e++) begin
         @(posedge clk);
         #1;
         if (done0) begin c0++; if (d0 < 0) d0 = e; end
         if (done1) begin c1++; if (d1 < 0) d1 = e; end
         start  = ((e + 1) == v.rs_a) || ((e + 1) == v.rs_b);
         abort  = ((e + 1) == v.abort_at);
         exp_tt = 4'($urandom);
      end
      start = 1'b0; abort = 1'b0;
      chk({v.name, "/cap0"},  32'(cap0),  32'(v.cap0));
      chk({v.name, "/fail0"}, 32'(fm0),   32'(v.fail0));
      chk({v.name, "/pass0"}, 32'(pass0), 32'(v.pass0));
      chk({v.name, "/done0"}, d0, v.done0);
      chk({v.name, "/ndone0"}, c0, (v.done0 >= 0) ? 1 : 0);
      chk({v.name, "/cap1"},  32'(cap1),  32'(v.cap1));
      chk({v.name, "/fail1"}, 32'(fm1),   32'(v.fail1));
      chk({v.name, "/pass1"}, 32'(pass1), 32'(v.pass1));
      chk({v.name, "/done1"}, d1, v.done1);
      chk({v.name, "/ndone1"}, c1, (v.done1 >= 0) ? 1 : 0);
   endtask

   initial begin
      int h0a, h0b, h1a, h1b;
      tbl[0] = '{"and_pass",  4'b1000, 4'b1000, -1, -1, -1, 4'b1000, 4'b0000, 1'b1, 12, 4'b1000, 4'b0000, 1'b1, 8};
      tbl[1] = '{"and_vs_or", 4'b1000, 4'b1110, -1, -1, -1, 4'b1000, 4'b0110, 1'b0, 12, 4'b1000, 4'b0110, 1'b0, 8};
      tbl[2] = '{"restart",   4'b1000, 4'b1000, -1,  3,  7, 4'b1000, 4'b0000, 1'b1, 12, 4'b1000, 4'b0000, 1'b1, 8};
      tbl[3] = '{"abort7",    4'b1000, 4'b1000,  7, -1, -1, 4'b0000, 4'b0000, 1'b0, -1, 4'b0000, 4'b0000, 1'b0, -1};
      tbl[4] = '{"abort7_or", 4'b1110, 4'b1110,  7, -1, -1, 4'b0010, 4'b0000, 1'b0, -1, 4'b0110, 4'b0000, 1'b0, -1};
      tbl[5] = '{"xor",       4'b0110, 4'b1001, -1, -1, -1, 4'b0110, 4'b1111, 1'b0, 12, 4'b0110, 4'b1111, 1'b0, 8};
      tbl[6] = '{"nand",      4'b0111, 4'b0111, -1, -1, -1, 4'b0111, 4'b0000, 1'b1, 12, 4'b0111, 4'b0000, 1'b1, 8};
      tbl[7] = '{"abort10",   4'b1110, 4'b1110, 10, -1, -1, 4'b0110, 4'b0000, 1'b0, -1, 4'b1110, 4'b0000, 1'b1, 8};

      @(posedge clk);
      #1;
      chk("reset0", 32'({busy0, done0, pass0, gin0, cap0, fm0}), 32'd0);
      chk("reset1", 32'({busy1, done1, pass1, gin1, cap1, fm1}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(tbl[i]);

      // Asynchronous reset in the middle of a sweep.
      do_reset();
      gut = 4'b1000; exp_tt = 4'b1000; start = 1'b1;
      for (int e = 0; e < 6; e++) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("rst_mid0", 32'({busy0, done0, pass0, gin0, cap0, fm0}), 32'd0);
      chk("rst_mid1", 32'({busy1, done1, pass1, gin1, cap1, fm1}), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("idle_post_rst0", 32'({busy0, done0, pass0, gin0, cap0, fm0}), 32'd0);
      chk("idle_post_rst1", 32'({busy1, done1, pass1, gin1, cap1, fm1}), 32'd0);

      // start held high through the done cycle re-launches a sweep.
      do_reset();
      gut = 4'b1000; exp_tt = 4'b1000; start = 1'b1;
      h0a = -1; h0b = -1; h1a = -1; h1b = -1;
      for (int e = 0; e < 31; e++) begin
         @(posedge clk);
         #1;
         if (done0) begin if (h0a < 0) h0a = e; else if (h0b < 0) h0b = e; end
         if (done1) begin if (h1a < 0) h1a = e; else if (h1b < 0) h1b = e; end
         if (e == 13) begin
            chk("hold_cleared_cap0", 32'(cap0), 32'd0);
            chk("hold_cleared_pass0", 32'(pass0), 32'd0);
            chk("hold_busy0", 32'(busy0), 32'd1);
            start = 1'b0;
         end
      end
      chk("hold_done0_a", h0a, 12);
      chk("hold_done0_b", h0b, 25);
      chk("hold_done1_a", h1a, 8);
      chk("hold_done1_b", h1b, 17);
      chk("hold_final_cap0", 32'(cap0), 32'b1000);
      chk("hold_final_pass0", 32'(pass0), 32'd1);

      // Random traffic against the sweep-level reference.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         @(posedge clk);
         #1;
         rst_n  = ($urandom % 150) != 0;
         start  = ($urandom % 4) == 0;
         abort  = ($urandom % 16) == 0;
         exp_tt = 4'($urandom);
         if (($urandom % 8) == 0) gut = 4'($urandom);
      end
      rst_n = 1'b1; start = 1'b0; abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
